calc_sram_responder: RTL and testbench
======================================

CALC_SRAM_RESPONDER -- requirements
Module: calc_sram_responder

Interface
REQ-001 Parameter: MEM_WORD_SIZE, 64 (package), stored word width in bits.
REQ-002 Parameter: ADDR_W, 9 (package), address width; depth = 2**ADDR_W = 512 words.
REQ-003 clk_i  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_i  input  1  reset, synchronous, active-high.
REQ-005 req_i  input  1  initiator request valid.
REQ-006 we_i  input  1  1 = write, 0 = read; sampled with req_i.
REQ-007 addr_i  input  ADDR_W  word address; sampled with req_i.
REQ-008 wdata_i  input  MEM_WORD_SIZE  write data; sampled with req_i.
REQ-009 err_inject_i  input  1  write-time parity corruption request; sampled with req_i.
REQ-010 ready_o  output  1  responder can accept a request this cycle.
REQ-011 rvalid_o  output  1  one-cycle pulse; rdata_o valid.
REQ-012 rdata_o  output  MEM_WORD_SIZE  read data.
REQ-013 wack_o  output  1  one-cycle pulse; write committed.
REQ-014 perr_o  output  1  parity error flag, qualified by rvalid_o.
REQ-015 init_done_o  output  1  post-reset memory clear complete.

Function
REQ-016 FSM states: R_INIT, R_IDLE, R_RACC, R_RDATA, R_WACC; state after reset is R_INIT.
REQ-017 R_INIT: 9-bit counter writes zero (and correct parity) to address 0..511, one per cycle; after address 511 -> R_IDLE; ready_o=0, init_done_o=0 throughout.
REQ-018 Acceptance: request accepted in the cycle req_i=1 and ready_o=1; ready_o=1 only in R_IDLE.
REQ-019 req_i while ready_o=0 is ignored, not queued; initiator holds req_i until accepted.
REQ-020 Read: accept -> R_RACC (synchronous array read) -> R_RDATA, rvalid_o=1 with rdata_o -> R_IDLE; rvalid_o asserts exactly 2 cycles after acceptance edge.
REQ-021 Write: accept -> R_WACC, array written at this edge, wack_o=1 -> R_IDLE; wack_o asserts 1 cycle after acceptance.
REQ-022 Back-to-back: minimum request spacing is 3 cycles for reads, 2 for writes; read immediately after write to same address returns new data.
REQ-023 rdata_o holds last read value until next rvalid_o; outside rvalid_o it is don't-care for the initiator.
REQ-024 Address wraps naturally (9 bits); no out-of-range case exists.
REQ-025 rvalid_o and wack_o never assert in the same cycle.

Reset
REQ-026 rst_i asserted in any state, including mid-access or mid-init: next state R_INIT, counter=0, pending access abandoned (no rvalid_o/wack_o).
REQ-027 Output reset values: ready_o=0, rvalid_o=0, rdata_o=0, wack_o=0, perr_o=0, init_done_o=0.
REQ-028 init_done_o rises on entry to R_IDLE and stays 1 until next reset.

Configuration
REQ-029 Macro CALC_SRAM_PARITY_EN: when defined, each word stores an even-parity bit; err_inject_i=1 on accepted write stores inverted parity; on read perr_o=1 with rvalid_o if recomputed parity mismatches.
REQ-030 Without CALC_SRAM_PARITY_EN: no parity storage, err_inject_i ignored, perr_o tied 0; all other timing identical.

Structure
REQ-031 calculator_pkg gains resp_state_t enum (R_INIT..R_WACC) and constant MEM_DEPTH = 2**ADDR_W; MEM_WORD_SIZE, ADDR_W taken from it.
REQ-032 One sub-module calc_sram_array: 1 write port, 1 registered read port, width MEM_WORD_SIZE (+1 when parity enabled), no reset on storage.

Verification
REQ-033 Reset then idle: init_done_o rises 512 cycles after rst_i deassert; ready_o=1 same cycle; read addr 0x1FF -> rdata_o=0.
REQ-034 Write addr 0x005 data 0x0000_0001_0000_0002 -> wack_o next cycle; read 0x005 -> rvalid_o 2 cycles after accept, rdata_o=0x0000_0001_0000_0002.
REQ-035 req_i held during R_RACC/R_WACC -> no second acceptance until ready_o=1; exactly one rvalid_o/wack_o per accepted request.
REQ-036 rst_i pulsed one cycle after read accept -> no rvalid_o; ready_o=0 for 512 cycles; prior data reads back 0.
REQ-037 Parity enabled: write 0xFF to 0x010 with err_inject_i=1, read 0x010 -> perr_o=1 with rvalid_o; write 0x010 again with err_inject_i=0, read -> perr_o=0.
REQ-038 Parity disabled: same stimulus as REQ-037 -> perr_o=0 always, rdata_o=0xFF.

Source files
------------

// File: rtl/calculator_pkg.sv
// Shared widths, depth and responder state encoding for the calculator SRAM path.
package calculator_pkg;

    localparam int MEM_WORD_SIZE = 64;
    localparam int ADDR_W        = 9;
    localparam int MEM_DEPTH     = 2 ** ADDR_W;

    typedef enum logic [2:0] {
        R_INIT  = 3'd0,
        R_IDLE  = 3'd1,
        R_RACC  = 3'd2,
        R_RDATA = 3'd3,
        R_WACC  = 3'd4
    } resp_state_t;

    function automatic logic even_parity(input logic [MEM_WORD_SIZE-1:0] word);
        return ^word;
    endfunction

endpackage

// File: rtl/calc_sram_array.sv
// Single write port, registered read port storage; contents are not reset.
module calc_sram_array #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 512,
    parameter int AW    = 9
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/calc_sram_responder.sv
// SRAM responder: clears memory after reset, then serves single read/write requests.
// Optional per-word even parity with error injection when CALC_SRAM_PARITY_EN is defined.
//
// state   | meaning
// R_INIT  | clearing address cnt to zero, one word per cycle
// R_IDLE  | ready_o=1, waiting for req_i
// R_RACC  | array read of latched address in flight
// R_RDATA | array output valid; rvalid_o pulses on exit
// R_WACC  | latched write committed at exit edge; wack_o pulses on exit
module calc_sram_responder
    import calculator_pkg::*;
(
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     req_i,
    input  logic                     we_i,
    input  logic [ADDR_W-1:0]        addr_i,
    input  logic [MEM_WORD_SIZE-1:0] wdata_i,
    input  logic                     err_inject_i,
    output logic                     ready_o,
    output logic                     rvalid_o,
    output logic [MEM_WORD_SIZE-1:0] rdata_o,
    output logic                     wack_o,
    output logic                     perr_o,
    output logic                     init_done_o
);

`ifdef CALC_SRAM_PARITY_EN
    localparam int STORE_W = MEM_WORD_SIZE + 1;
`else
    localparam int STORE_W = MEM_WORD_SIZE;
`endif

    resp_state_t              state;
    logic [ADDR_W-1:0]        cnt;
    logic [ADDR_W-1:0]        addr_q;
    logic [MEM_WORD_SIZE-1:0] wdata_q;
    logic                     inj_q;
    logic                     mem_we;
    logic [ADDR_W-1:0]        mem_waddr;
    logic [STORE_W-1:0]       mem_wdata;
    logic [STORE_W-1:0]       store_word;
    logic [STORE_W-1:0]       mem_rdata;
    logic                     read_perr;

`ifdef CALC_SRAM_PARITY_EN
    assign store_word = {even_parity(wdata_q) ^ inj_q, wdata_q};
    assign read_perr  = ^mem_rdata;
`else
    logic unused_inj;
    assign unused_inj = inj_q;
    assign store_word = wdata_q;
    assign read_perr  = 1'b0;
`endif

    // Writes are suppressed while rst_i is high so a reset in R_WACC abandons the write.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = cnt;
        mem_wdata = '0;
        if (!rst_i) begin
            if (state == R_INIT) begin
                mem_we = 1'b1;
            end else if (state == R_WACC) begin
                mem_we    = 1'b1;
                mem_waddr = addr_q;
                mem_wdata = store_word;
            end
        end
    end

    calc_sram_array #(
        .WIDTH (STORE_W),
        .DEPTH (MEM_DEPTH),
        .AW    (ADDR_W)
    ) u_array (
        .clk   (clk_i),
        .we    (mem_we),
        .waddr (mem_waddr),
        .wdata (mem_wdata),
        .raddr (addr_q),
        .rdata (mem_rdata)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= R_INIT;
            cnt         <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            inj_q       <= 1'b0;
            ready_o     <= 1'b0;
            rvalid_o    <= 1'b0;
            rdata_o     <= '0;
            wack_o      <= 1'b0;
            perr_o      <= 1'b0;
            init_done_o <= 1'b0;
        end else begin
            rvalid_o <= 1'b0;
            wack_o   <= 1'b0;
            perr_o   <= 1'b0;
            case (state)
                R_INIT: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == '1) begin
                        state       <= R_IDLE;
                        ready_o     <= 1'b1;
                        init_done_o <= 1'b1;
                    end
                end
                R_IDLE: begin
                    if (req_i) begin
                        addr_q  <= addr_i;
                        wdata_q <= wdata_i;
                        inj_q   <= err_inject_i;
                        ready_o <= 1'b0;
                        state   <= we_i ? R_WACC : R_RACC;
                    end
                end
                R_RACC: begin
                    state <= R_RDATA;
                end
                R_RDATA: begin
                    rvalid_o <= 1'b1;
                    rdata_o  <= mem_rdata[MEM_WORD_SIZE-1:0];
                    perr_o   <= read_perr;
                    ready_o  <= 1'b1;
                    state    <= R_IDLE;
                end
                R_WACC: begin
                    wack_o  <= 1'b1;
                    ready_o <= 1'b1;
                    state   <= R_IDLE;
                end
                default: begin
                    state <= R_INIT;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_calc_sram_responder.sv
// Directed self-checking bench for calc_sram_responder (honours CALC_SRAM_PARITY_EN).
module tb_calc_sram_responder;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        req_i = 1'b0;
    logic        we_i = 1'b0;
    logic [8:0]  addr_i = '0;
    logic [63:0] wdata_i = '0;
    logic        err_inject_i = 1'b0;
    logic        ready_o, rvalid_o, wack_o, perr_o, init_done_o;
    logic [63:0] rdata_o;

    int total = 0;
    int passed = 0;

`ifdef CALC_SRAM_PARITY_EN
    localparam logic PERR_INJ = 1'b1;
`else
    localparam logic PERR_INJ = 1'b0;
`endif

    calc_sram_responder dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .req_i        (req_i),
        .we_i         (we_i),
        .addr_i       (addr_i),
        .wdata_i      (wdata_i),
        .err_inject_i (err_inject_i),
        .ready_o      (ready_o),
        .rvalid_o     (rvalid_o),
        .rdata_o      (rdata_o),
        .wack_o       (wack_o),
        .perr_o       (perr_o),
        .init_done_o  (init_done_o)
    );

    always #5 clk_i = ~clk_i;

    // Called at a negedge; returns at the first negedge with ready_o=1.
    task automatic wait_ready(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 1200; i++) begin
            if (ready_o) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk_i);
        end
    endtask

    // lat counts negedges after the acceptance edge (0 = right after it); -1 on timeout.
    task automatic do_read(input logic [8:0] a, output logic [63:0] d, output logic pe,
                           output int lat, output int nvalid);
        bit ok;
        d = '0; pe = 1'b0; lat = -1; nvalid = 0;
        wait_ready(ok);
        if (!ok) return;
        req_i = 1'b1; we_i = 1'b0; addr_i = a; err_inject_i = 1'b0;
        @(negedge clk_i);
        req_i = 1'b0;
        for (int c = 0; c < 5; c++) begin
            if (rvalid_o) begin
                nvalid++;
                if (lat < 0) begin
                    lat = c; d = rdata_o; pe = perr_o;
                end
            end
            @(negedge clk_i);
        end
    endtask

    task automatic do_write(input logic [8:0] a, input logic [63:0] d, input logic inj,
                            output int lat, output int nack);
        bit ok;
        lat = -1; nack = 0;
        wait_ready(ok);
        if (!ok) return;
        req_i = 1'b1; we_i = 1'b1; addr_i = a; wdata_i = d; err_inject_i = inj;
        @(negedge clk_i);
        req_i = 1'b0; we_i = 1'b0; err_inject_i = 1'b0;
        for (int c = 0; c < 4; c++) begin
            if (wack_o) begin
                nack++;
                if (lat < 0) lat = c;
            end
            @(negedge clk_i);
        end
    endtask

    task automatic test_reset();
        int cyc;
        bit early_ready;
        logic [63:0] d; logic pe; int lat, nv;
        rst_i = 1'b1;
        repeat (3) @(negedge clk_i);
        total++; if (ready_o !== 1'b0) $display("FAIL rst_ready got=%b exp=0", ready_o); else passed++;
        total++; if (rvalid_o !== 1'b0) $display("FAIL rst_rvalid got=%b exp=0", rvalid_o); else passed++;
        total++; if (rdata_o !== 64'd0) $display("FAIL rst_rdata got=%h exp=0", rdata_o); else passed++;
        total++; if (wack_o !== 1'b0) $display("FAIL rst_wack got=%b exp=0", wack_o); else passed++;
        total++; if (perr_o !== 1'b0) $display("FAIL rst_perr got=%b exp=0", perr_o); else passed++;
        total++; if (init_done_o !== 1'b0) $display("FAIL rst_init_done got=%b exp=0", init_done_o); else passed++;
        rst_i = 1'b0;
        cyc = 0; early_ready = 1'b0;
        for (int i = 0; i < 700; i++) begin
            @(negedge clk_i);
            cyc++;
            if (init_done_o) break;
            if (ready_o) early_ready = 1'b1;
        end
        total++; if (cyc !== 512) $display("FAIL init_latency got=%0d exp=512", cyc); else passed++;
        total++; if (ready_o !== 1'b1) $display("FAIL init_ready got=%b exp=1", ready_o); else passed++;
        total++; if (early_ready !== 1'b0) $display("FAIL init_ready_early got=%b exp=0", early_ready); else passed++;
        do_read(9'h1FF, d, pe, lat, nv);
        total++; if (d !== 64'd0) $display("FAIL read_1ff_data got=%h exp=0", d); else passed++;
        total++; if (lat !== 2) $display("FAIL read_1ff_latency got=%0d exp=2", lat); else passed++;
    endtask

    task automatic test_write_read();
        logic [63:0] d; logic pe; int lat, n;
        do_write(9'h005, 64'h0000_0001_0000_0002, 1'b0, lat, n);
        total++; if (lat !== 1) $display("FAIL wr5_latency got=%0d exp=1", lat); else passed++;
        total++; if (n !== 1) $display("FAIL wr5_wack_count got=%0d exp=1", n); else passed++;
        do_read(9'h005, d, pe, lat, n);
        total++; if (lat !== 2) $display("FAIL rd5_latency got=%0d exp=2", lat); else passed++;
        total++; if (d !== 64'h0000_0001_0000_0002) $display("FAIL rd5_data got=%h exp=0000000100000002", d); else passed++;
        total++; if (n !== 1) $display("FAIL rd5_rvalid_count got=%0d exp=1", n); else passed++;
        do_write(9'h000, 64'hDEAD_BEEF_CAFE_F00D, 1'b0, lat, n);
        do_write(9'h1FF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, lat, n);
        do_read(9'h000, d, pe, lat, n);
        total++; if (d !== 64'hDEAD_BEEF_CAFE_F00D) $display("FAIL rd0_data got=%h exp=deadbeefcafef00d", d); else passed++;
        do_read(9'h1FF, d, pe, lat, n);
        total++; if (d !== 64'hFFFF_FFFF_FFFF_FFFF) $display("FAIL rd1ff_data got=%h exp=ffffffffffffffff", d); else passed++;
        do_read(9'h005, d, pe, lat, n);
        total++; if (d !== 64'h0000_0001_0000_0002) $display("FAIL rd5_again got=%h exp=0000000100000002", d); else passed++;
    endtask

    task automatic test_back_to_back();
        bit ok;
        wait_ready(ok);
        req_i = 1'b1; we_i = 1'b1; addr_i = 9'h033; wdata_i = 64'h0123_4567_89AB_CDEF;
        @(negedge clk_i);
        req_i = 1'b0; we_i = 1'b0;
        @(negedge clk_i);
        total++; if (wack_o !== 1'b1) $display("FAIL b2b_wack got=%b exp=1", wack_o); else passed++;
        total++; if (ready_o !== 1'b1) $display("FAIL b2b_ready_after_wr got=%b exp=1", ready_o); else passed++;
        req_i = 1'b1; addr_i = 9'h033;
        @(negedge clk_i);
        req_i = 1'b0;
        @(negedge clk_i);
        total++; if (rvalid_o !== 1'b0) $display("FAIL b2b_rvalid_early got=%b exp=0", rvalid_o); else passed++;
        @(negedge clk_i);
        total++; if (rvalid_o !== 1'b1) $display("FAIL b2b_rvalid got=%b exp=1", rvalid_o); else passed++;
        total++; if (rdata_o !== 64'h0123_4567_89AB_CDEF) $display("FAIL b2b_rdata got=%h exp=0123456789abcdef", rdata_o); else passed++;
        total++; if (wack_o !== 1'b0) $display("FAIL b2b_wack_with_rvalid got=%b exp=0", wack_o); else passed++;
    endtask

    task automatic test_held_req();
        bit ok;
        int nv, nw, first;
        wait_ready(ok);
        req_i = 1'b1; we_i = 1'b0; addr_i = 9'h005;
        nv = 0; first = -1;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk_i);
            if (rvalid_o) begin
                nv++;
                if (first < 0) first = c;
            end
        end
        req_i = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk_i);
            if (rvalid_o) nv++;
        end
        total++; if (nv !== 2) $display("FAIL held_read_count got=%0d exp=2", nv); else passed++;
        total++; if (first !== 3) $display("FAIL held_read_first got=%0d exp=3", first); else passed++;
        wait_ready(ok);
        req_i = 1'b1; we_i = 1'b1; addr_i = 9'h044; wdata_i = 64'h55;
        nw = 0; nv = 0;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk_i);
            if (wack_o) nw++;
            if (rvalid_o) nv++;
        end
        req_i = 1'b0; we_i = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk_i);
            if (wack_o) nw++;
        end
        total++; if (nw !== 2) $display("FAIL held_write_count got=%0d exp=2", nw); else passed++;
        total++; if (nv !== 0) $display("FAIL held_write_rvalid got=%0d exp=0", nv); else passed++;
    endtask

    task automatic test_reset_mid_read();
        bit ok, seen_valid, seen_ready;
        int cyc;
        logic [63:0] d; logic pe; int lat, n;
        do_write(9'h020, 64'h1234, 1'b0, lat, n);
        wait_ready(ok);
        req_i = 1'b1; we_i = 1'b0; addr_i = 9'h020;
        @(negedge clk_i);
        req_i = 1'b0; rst_i = 1'b1;
        seen_valid = 1'b0; seen_ready = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b0;
        if (rvalid_o) seen_valid = 1'b1;
        cyc = 0;
        for (int i = 0; i < 700; i++) begin
            @(negedge clk_i);
            cyc++;
            if (rvalid_o) seen_valid = 1'b1;
            if (init_done_o) break;
            if (ready_o) seen_ready = 1'b1;
        end
        total++; if (seen_valid !== 1'b0) $display("FAIL midrst_rvalid got=%b exp=0", seen_valid); else passed++;
        total++; if (seen_ready !== 1'b0) $display("FAIL midrst_ready_during_init got=%b exp=0", seen_ready); else passed++;
        total++; if (cyc !== 512) $display("FAIL midrst_init_latency got=%0d exp=512", cyc); else passed++;
        do_read(9'h020, d, pe, lat, n);
        total++; if (d !== 64'd0) $display("FAIL midrst_rd20 got=%h exp=0", d); else passed++;
        do_read(9'h005, d, pe, lat, n);
        total++; if (d !== 64'd0) $display("FAIL midrst_rd5 got=%h exp=0", d); else passed++;
    endtask

    task automatic test_parity();
        logic [63:0] d; logic pe; int lat, n;
        do_write(9'h010, 64'hFF, 1'b1, lat, n);
        do_read(9'h010, d, pe, lat, n);
        total++; if (pe !== PERR_INJ) $display("FAIL par_inj_perr got=%b exp=%b", pe, PERR_INJ); else passed++;
        total++; if (d !== 64'hFF) $display("FAIL par_inj_data got=%h exp=ff", d); else passed++;
        do_write(9'h010, 64'hFF, 1'b0, lat, n);
        do_read(9'h010, d, pe, lat, n);
        total++; if (pe !== 1'b0) $display("FAIL par_clean_perr got=%b exp=0", pe); else passed++;
        total++; if (d !== 64'hFF) $display("FAIL par_clean_data got=%h exp=ff", d); else passed++;
        do_write(9'h011, 64'h7, 1'b1, lat, n);
        do_read(9'h011, d, pe, lat, n);
        total++; if (pe !== PERR_INJ) $display("FAIL par_odd_perr got=%b exp=%b", pe, PERR_INJ); else passed++;
    endtask

    initial begin
        @(negedge clk_i);
        test_reset();
        test_write_read();
        test_back_to_back();
        test_held_req();
        test_reset_mid_read();
        test_parity();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
